// File: rtl/reclass_histogram.sv
// reclass_histogram
//   Tallies reclassified raster cells per class over one frame. After the
//   frame's last cell the six tallies are streamed out one word per
//   handshake, and then every counter clears for the next frame.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   ACCUM | accepting cells, counting M1/M2/M3/N0/N5/ERR
//   DUMP  | streaming tallies idx 0..5, input stalled, counters frozen
//
// Ports
//   clk, rst_n           system clock, async active-low reset
//   in_valid/in_ready    cell handshake (in_ready is high only in ACCUM)
//   in_m, in_n, in_last  3-class code, 2-class code, end-of-frame flag
//   out_valid/out_ready  tally word handshake
//   out_idx              0=M1 1=M2 2=M3 3=N0 4=N5 5=ERR
//   out_data             tally for out_idx (reads 0 outside DUMP)
//   out_last             marks the ERR word, the final word of a dump
module reclass_histogram #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_m,
  input  logic [3:0]       in_n,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_idx,
  output logic [CNT_W-1:0] out_data,
  output logic             out_last
);

  typedef enum logic {ACCUM = 1'b0, DUMP = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [2:0]       IDX_ERR = 3'd5;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] out_data_q, out_data_d;

  logic             m_legal, n_legal;
  logic [5:0]       hit;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    hit      = '0;
    m_legal  = (in_m == 4'd1) || (in_m == 4'd2) || (in_m == 4'd3);
    n_legal  = (in_n == 4'd0) || (in_n == 4'd5);

    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          hit[0] = (in_m == 4'd1);
          hit[1] = (in_m == 4'd2);
          hit[2] = (in_m == 4'd3);
          hit[3] = (in_n == 4'd0);
          hit[4] = (in_n == 4'd5);
          // one ERR count per cell regardless of how many fields are bad
          hit[5] = !(m_legal && n_legal);
          for (int k = 0; k < 6; k++) begin
            if (hit[k] && (cnt_q[k] != CNT_MAX)) cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
          if (in_last) begin
            state_d = DUMP;
            idx_d   = 3'd0;
          end
        end
      end
      DUMP: begin
        if (out_ready) begin
          if (idx_q == IDX_ERR) begin
            state_d = ACCUM;
            idx_d   = 3'd0;
            for (int k = 0; k < 6; k++) cnt_d[k] = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ACCUM;
    endcase

    // Outputs are registered from next-state values so they line up with
    // state_q/idx_q on the following cycle.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DUMP);
    out_last_d  = (state_d == DUMP) && (idx_d == IDX_ERR);
    out_data_d  = '0;
    if (state_d == DUMP) begin
      case (idx_d)
        3'd0:    out_data_d = cnt_d[0];
        3'd1:    out_data_d = cnt_d[1];
        3'd2:    out_data_d = cnt_d[2];
        3'd3:    out_data_d = cnt_d[3];
        3'd4:    out_data_d = cnt_d[4];
        3'd5:    out_data_d = cnt_d[5];
        default: out_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      idx_q       <= 3'd0;
      for (int k = 0; k < 6; k++) cnt_q[k] <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;

endmodule

// File: tb/tb_reclass_histogram.sv
// tb_reclass_histogram
//   Directed bench for reclass_histogram: frame tallies, illegal codes,
//   saturation, output backpressure, input ignored during dump, and
//   asynchronous reset in the middle of a dump.
module tb_reclass_histogram;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_m;
  logic [3:0]       in_n;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_idx;
  logic [CNT_W-1:0] out_data;
  logic             out_last;

  int n_assert = 0;
  int n_fail   = 0;

  reclass_histogram #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_m      (in_m),
    .in_n      (in_n),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] m, input logic [3:0] n, input logic last);
    in_valid = 1'b1;
    in_m     = m;
    in_n     = n;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Full dump with out_ready held high; ends one cycle after the idx5 transfer.
  task automatic dump_check(input string tag, input int e0, input int e1, input int e2,
                            input int e3, input int e4, input int e5);
    int exp_w [6];
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2;
    exp_w[3] = e3; exp_w[4] = e4; exp_w[5] = e5;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check({tag, " valid"},    32'(out_valid), 32'd1);
      check({tag, " idx"},      32'(out_idx),   32'(i));
      check({tag, " data"},     32'(out_data),  32'(exp_w[i]));
      check({tag, " last"},     32'(out_last),  32'(i == 5));
      check({tag, " in_ready"}, 32'(in_ready),  32'd0);
      tick();
    end
    check({tag, " post valid"},    32'(out_valid), 32'd0);
    check({tag, " post in_ready"}, 32'(in_ready),  32'd1);
    check({tag, " post data"},     32'(out_data),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_m      = 4'd0;
    in_n      = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // reset state
    check("rst in_ready",  32'(in_ready),  32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_last",  32'(out_last),  32'd0);
    check("rst out_data",  32'(out_data),  32'd0);
    check("rst out_idx",   32'(out_idx),   32'd0);

    // basic frame
    out_ready = 1'b1;
    send(4'd1, 4'd0, 1'b0);
    send(4'd2, 4'd5, 1'b0);
    send(4'd3, 4'd0, 1'b0);
    send(4'd1, 4'd5, 1'b1);
    dump_check("basic", 2, 1, 1, 2, 2, 0);

    // illegal codes
    send(4'd0, 4'd0, 1'b0);
    send(4'd2, 4'd7, 1'b0);
    send(4'd9, 4'd9, 1'b1);
    dump_check("illegal", 0, 1, 0, 1, 0, 3);

    // saturation
    for (int i = 0; i < 300; i++) send(4'd1, 4'd5, 1'b0);
    send(4'd1, 4'd5, 1'b1);
    dump_check("sat", 255, 0, 0, 0, 255, 0);

    // backpressure: frame gives M1=1 M2=1 M3=1 N0=2 N5=1 ERR=0
    send(4'd1, 4'd0, 1'b0);
    send(4'd2, 4'd5, 1'b0);
    send(4'd3, 4'd0, 1'b1);
    out_ready = 1'b1;
    check("bp idx0 data", 32'(out_data), 32'd1);
    tick();
    check("bp idx1 idx", 32'(out_idx), 32'd1);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp hold2 idx",   32'(out_idx),   32'd2);
      check("bp hold2 data",  32'(out_data),  32'd1);
      check("bp hold2 valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp idx3 idx",  32'(out_idx),  32'd3);
    check("bp idx3 data", 32'(out_data), 32'd2);
    out_ready = 1'b0;
    tick();
    check("bp hold3 idx",  32'(out_idx),  32'd3);
    check("bp hold3 data", 32'(out_data), 32'd2);
    out_ready = 1'b1;
    tick();
    check("bp idx4 idx",  32'(out_idx),  32'd4);
    check("bp idx4 data", 32'(out_data), 32'd1);
    out_ready = 1'b0;
    tick();
    check("bp hold4 idx", 32'(out_idx), 32'd4);
    out_ready = 1'b1;
    tick();
    check("bp idx5 idx",  32'(out_idx),  32'd5);
    check("bp idx5 last", 32'(out_last), 32'd1);
    out_ready = 1'b0;
    tick();
    check("bp hold5 valid", 32'(out_valid), 32'd1);
    check("bp hold5 idx",   32'(out_idx),   32'd5);
    check("bp hold5 last",  32'(out_last),  32'd1);
    out_ready = 1'b1;
    tick();
    check("bp done valid",    32'(out_valid), 32'd0);
    check("bp done in_ready", 32'(in_ready),  32'd1);

    // in_valid held through dump must be ignored; next frame starts clean
    send(4'd2, 4'd0, 1'b1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_m    = 4'(i + 1);
      in_n    = (i % 2 == 0) ? 4'd5 : 4'd0;
      in_last = (i == 2);
      check("ign idx",  32'(out_idx),  32'(i));
      check("ign data", 32'(out_data), (i == 1 || i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("ign post in_ready", 32'(in_ready),  32'd1);
    check("ign post valid",    32'(out_valid), 32'd0);
    in_m    = 4'd3;
    in_n    = 4'd5;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    dump_check("b2b", 0, 0, 1, 0, 1, 0);

    // reset in the middle of a dump
    send(4'd1, 4'd0, 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("mid idx3", 32'(out_idx), 32'd3);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst valid", 32'(out_valid), 32'd0);
    check("mid rst idx",   32'(out_idx),   32'd0);
    check("mid rst last",  32'(out_last),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid rel in_ready", 32'(in_ready),  32'd1);
    check("mid rel valid",    32'(out_valid), 32'd0);
    send(4'd3, 4'd0, 1'b1);
    dump_check("after rst", 0, 0, 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
